// File: rtl/jtframe_dual_ram_be.sv
// Single-clock true dual-port RAM with per-byte write enables, optional write
// forwarding, 1- or 2-cycle read pipeline and a clear engine that fills the array.
module jtframe_dual_ram_be #(
  parameter int              DW         = 16,
  parameter int              AW         = 10,
  parameter int              LATENCY    = 1,
  parameter int              FWD        = 1,
  parameter int              CLR_ON_RST = 1,
  parameter logic [DW-1:0]   CLR_VAL    = '0,
  parameter                  SYNFILE    = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               clr_busy,
  input  logic [AW-1:0]      addr0,
  input  logic [DW-1:0]      data0,
  input  logic [DW/8-1:0]    we0,
  output logic [DW-1:0]      q0,
  input  logic [AW-1:0]      addr1,
  input  logic [DW-1:0]      data1,
  input  logic [DW/8-1:0]    we1,
  output logic [DW-1:0]      q1
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_s1_q0, r_s1_q1;
  logic [DW-1:0] w_rd0, w_rd1;
  logic          w_busy;

  assign w_busy   = (r_state == ST_CLEAR);
  assign clr_busy = w_busy;

  // The preload image named by SYNFILE is attached by the vendor RAM flow.
  if (SYNFILE != "") begin : g_preload
  end

  // Clear engine: clr is only honoured in IDLE, so a pulse mid-clear cannot restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {AW{1'b1}}) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Array is never reset; port 0 is written last so it wins byte collisions.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= CLR_VAL;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (we1[b]) r_mem[addr1][8*b +: 8] <= data1[8*b +: 8];
        if (we0[b]) r_mem[addr0][8*b +: 8] <= data0[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rd0 = r_mem[addr0];
    w_rd1 = r_mem[addr1];
    if (FWD != 0) begin
      for (int b = 0; b < NB; b++) begin
        if (we1[b] && (addr1 == addr0)) w_rd0[8*b +: 8] = data1[8*b +: 8];
        if (we0[b])                     w_rd0[8*b +: 8] = data0[8*b +: 8];
        if (we1[b])                     w_rd1[8*b +: 8] = data1[8*b +: 8];
        if (we0[b] && (addr0 == addr1)) w_rd1[8*b +: 8] = data0[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_q0 <= '0;
      r_s1_q1 <= '0;
    end else begin
      r_s1_q0 <= w_busy ? '0 : w_rd0;
      r_s1_q1 <= w_busy ? '0 : w_rd1;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [DW-1:0] r_s2_q0, r_s2_q1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_q0 <= '0;
        r_s2_q1 <= '0;
      end else begin
        r_s2_q0 <= r_s1_q0;
        r_s2_q1 <= r_s1_q1;
      end
    end
    assign q0 = r_s2_q0;
    assign q1 = r_s2_q1;
  end else begin : g_lat1
    assign q0 = r_s1_q0;
    assign q1 = r_s1_q1;
  end

endmodule

// File: tb/tb_jtframe_dual_ram_be.sv
// Directed bench for jtframe_dual_ram_be: four instances share one stimulus set
// (0: FWD=1, 1: FWD=0, 2: LATENCY=2, 3: CLR_ON_RST=0 with CLR_VAL=5A3C).
module tb_jtframe_dual_ram_be;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic [1:0]  we0, we1;
  logic [15:0] q0v [4];
  logic [15:0] q1v [4];
  logic        busy [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jtframe_dual_ram_be #(.DW(16), .AW(4), .LATENCY(1), .FWD(1), .CLR_ON_RST(1), .CLR_VAL(16'hA5A5))
    u_fwd (.clk(clk), .rst_n(rst_n), .clr(clr), .clr_busy(busy[0]),
           .addr0(addr0), .data0(data0), .we0(we0), .q0(q0v[0]),
           .addr1(addr1), .data1(data1), .we1(we1), .q1(q1v[0]));
  jtframe_dual_ram_be #(.DW(16), .AW(4), .LATENCY(1), .FWD(0), .CLR_ON_RST(1), .CLR_VAL(16'hA5A5))
    u_old (.clk(clk), .rst_n(rst_n), .clr(clr), .clr_busy(busy[1]),
           .addr0(addr0), .data0(data0), .we0(we0), .q0(q0v[1]),
           .addr1(addr1), .data1(data1), .we1(we1), .q1(q1v[1]));
  jtframe_dual_ram_be #(.DW(16), .AW(4), .LATENCY(2), .FWD(1), .CLR_ON_RST(1), .CLR_VAL(16'hA5A5))
    u_lat2 (.clk(clk), .rst_n(rst_n), .clr(clr), .clr_busy(busy[2]),
            .addr0(addr0), .data0(data0), .we0(we0), .q0(q0v[2]),
            .addr1(addr1), .data1(data1), .we1(we1), .q1(q1v[2]));
  jtframe_dual_ram_be #(.DW(16), .AW(4), .LATENCY(1), .FWD(1), .CLR_ON_RST(0), .CLR_VAL(16'h5A3C))
    u_man (.clk(clk), .rst_n(rst_n), .clr(clr), .clr_busy(busy[3]),
           .addr0(addr0), .data0(data0), .we0(we0), .q0(q0v[3]),
           .addr1(addr1), .data1(data1), .we1(we1), .q1(q1v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int i);
    logic [3:0] a, b;
    a = 4'(i);
    b = 4'(15 - i);
    return {a, 4'hC, b, 4'h3};
  endfunction

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; we0 = '0; we1 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy_fwd", 32'(busy[0]), 1);
    check("rst_busy_man", 32'(busy[3]), 0);
    check("rst_q0_fwd",   32'(q0v[0]), 0);
    check("rst_q1_lat2",  32'(q1v[2]), 0);

    // Power-up clear; writes to address 2 attempted throughout must be dropped
    rst_n = 1'b1;
    addr0 = 4'd2; data0 = 16'hFFFF; we0 = 2'b11;
    cnt = 0;
    while (busy[0] && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    we0 = 2'b00;
    check("pwr_clr_len_fwd", 32'(cnt), 16);
    check("pwr_clr_done_lat2", 32'(busy[2]), 0);

    for (int k = 0; k < 18; k++) begin
      if (k >= 1 && k <= 16) check($sformatf("pwr_clr_rd_fwd_%0d", k - 1), 32'(q0v[0]), 32'h0000A5A5);
      if (k >= 2 && k <= 17) check($sformatf("pwr_clr_rd_lat2_%0d", k - 2), 32'(q0v[2]), 32'h0000A5A5);
      if (k < 16) addr0 = 4'(k);
      @(negedge clk);
    end

    // Byte enables: full word then upper byte only from port 1
    addr0 = 4'd3; data0 = 16'h1234; we0 = 2'b11;
    @(negedge clk);
    we0 = 2'b00; addr1 = 4'd3; data1 = 16'hAB00; we1 = 2'b10;
    @(negedge clk);
    we1 = 2'b00;
    check("be_fwd_q0", 32'(q0v[0]), 32'h0000AB34);
    check("be_fwd_q1", 32'(q1v[0]), 32'h0000AB34);
    check("be_old_q0", 32'(q0v[1]), 32'h00001234);
    @(negedge clk);
    check("be_old_q0_next", 32'(q0v[1]), 32'h0000AB34);

    // Collision on address 5: port 0 owns both bytes
    addr0 = 4'd5; addr1 = 4'd5;
    data0 = 16'h1111; we0 = 2'b11; data1 = 16'h2222; we1 = 2'b01;
    @(negedge clk);
    we0 = 2'b00; we1 = 2'b00;
    check("col_fwd_q0", 32'(q0v[0]), 32'h00001111);
    check("col_fwd_q1", 32'(q1v[0]), 32'h00001111);
    check("col_old_q0", 32'(q0v[1]), 32'h0000A5A5);
    check("col_old_q1", 32'(q1v[1]), 32'h0000A5A5);
    @(negedge clk);
    check("col_old_q0_next", 32'(q0v[1]), 32'h00001111);
    check("col_old_q1_next", 32'(q1v[1]), 32'h00001111);

    // Distinct pattern, then back-to-back sweep at both latencies
    for (int i = 0; i < 16; i++) begin
      addr0 = 4'(i); data0 = pat(i); we0 = 2'b11;
      @(negedge clk);
    end
    we0 = 2'b00;
    for (int k = 0; k < 18; k++) begin
      if (k >= 1 && k <= 16) begin
        check($sformatf("sweep_fwd_%0d", k - 1), 32'(q0v[0]), 32'(pat(k - 1)));
        check($sformatf("sweep_man_%0d", k - 1), 32'(q0v[3]), 32'(pat(k - 1)));
      end
      if (k >= 2 && k <= 17) check($sformatf("sweep_lat2_%0d", k - 2), 32'(q0v[2]), 32'(pat(k - 2)));
      if (k < 16) addr0 = 4'(k);
      @(negedge clk);
    end

    // Manual clear with an ignored clr pulse 5 cycles in
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("man_clr_rise", 32'(busy[3]), 1);
    cnt = 0;
    while (busy[3] && cnt < 100) begin
      cnt++;
      clr = (cnt == 5);
      if (cnt == 3) check("man_clr_q_zero", 32'(q0v[3]), 0);
      @(negedge clk);
    end
    clr = 1'b0;
    check("man_clr_len", 32'(cnt), 16);
    check("man_clr_done_fwd", 32'(busy[0]), 0);
    check("man_clr_last_q", 32'(q0v[3]), 0);

    addr1 = 4'd7; data1 = 16'hBEEF; we1 = 2'b11;
    @(negedge clk);
    we1 = 2'b00;
    for (int k = 0; k < 17; k++) begin
      if (k >= 1) begin
        check($sformatf("man_rd_%0d", k - 1), 32'(q0v[3]), (k - 1 == 7) ? 32'h0000BEEF : 32'h00005A3C);
        check($sformatf("man_rd_fwd_%0d", k - 1), 32'(q0v[0]), (k - 1 == 7) ? 32'h0000BEEF : 32'h0000A5A5);
      end
      if (k < 16) addr0 = 4'(k);
      @(negedge clk);
    end

    // Reset 8 cycles into a clear
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy_fwd", 32'(busy[0]), 1);
    check("midrst_busy_man", 32'(busy[3]), 0);
    check("midrst_q0_fwd",   32'(q0v[0]), 0);
    check("midrst_q0_lat2",  32'(q0v[2]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy[0] && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("midrst_clr_len", 32'(cnt), 16);
    for (int k = 0; k < 17; k++) begin
      if (k >= 1) check($sformatf("midrst_rd_%0d", k - 1), 32'(q0v[0]), 32'h0000A5A5);
      if (k < 16) addr0 = 4'(k);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
